// File: rtl/wb_thresh_pkg.sv
// Shared register-map constants and helpers for the Wishbone threshold monitor bank.
package wb_thresh_pkg;

  // Byte offsets; THRESH_c / SAMPLE_c repeat every OFS_STRIDE bytes per channel.
  localparam logic [31:0] OFS_ALARM   = 32'h0;
  localparam logic [31:0] OFS_MASK    = 32'h4;
  localparam logic [31:0] OFS_THRESH0 = 32'h8;
  localparam logic [31:0] OFS_SAMPLE0 = 32'hC;
  localparam logic [31:0] OFS_STRIDE  = 32'h8;

  // Bit positions of the LOW and HIGH fields inside a THRESH word.
  localparam int LOW_LSB  = 0;
  localparam int HIGH_LSB = 16;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{sel[b]}};
    return m;
  endfunction

endpackage

// File: rtl/wb_thresh_bank_if.sv
// Wishbone bus bundle for the threshold bank.
// Handshake: a request is cyc&stb with no same-direction access outstanding; the slave
// answers with a single-cycle ack one cycle later and holds stall while cyc&stb&~ack.
interface wb_thresh_bank_if #(
  parameter int ADR_W = 7
);
  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [3:0]       sel;
  logic [31:0]      dat_w;
  logic [31:0]      dat_r;
  logic             ack;
  logic             err;
  logic             rty;
  logic             stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_w,
    input  dat_r, ack, err, rty, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_w,
    output dat_r, ack, err, rty, stall
  );
endinterface

// File: rtl/wb_thresh_chan.sv
// One monitored channel: registered sample, LOW/HIGH window and the out-of-window compare.
module wb_thresh_chan
  import wb_thresh_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                wr_en,
  input  logic [31:0]         wdata,
  input  logic [31:0]         wmask,
  output logic [SAMPLE_W-1:0] sample_q,
  output logic [SAMPLE_W-1:0] low_q,
  output logic [SAMPLE_W-1:0] high_q,
  output logic                viol
);

  logic [SAMPLE_W-1:0] low_m;
  logic [SAMPLE_W-1:0] high_m;

  assign low_m  = wmask[LOW_LSB +: SAMPLE_W];
  assign high_m = wmask[HIGH_LSB +: SAMPLE_W];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sample_q <= '0;
      low_q    <= '0;
      high_q   <= '1;
    end else begin
      sample_q <= sample;
      if (wr_en) begin
        low_q  <= (low_q & ~low_m) | (wdata[LOW_LSB +: SAMPLE_W] & low_m);
        high_q <= (high_q & ~high_m) | (wdata[HIGH_LSB +: SAMPLE_W] & high_m);
      end
    end
  end

  // An inverted window (LOW > HIGH) makes every value violate.
  assign viol = (sample_q < low_q) || (sample_q > high_q);

endmodule

// File: rtl/wb_thresh_bank.sv
// Wishbone-mapped bank of N_CH window comparators with sticky W1C alarms and a masked level IRQ.
module wb_thresh_bank
  import wb_thresh_pkg::*;
#(
  parameter int N_CH     = 8,
  parameter int SAMPLE_W = 16,
  parameter int ADR_W    = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic [ADR_W-1:0]         wb_adr_i,
  input  logic [3:0]               wb_sel_i,
  input  logic                     wb_we_i,
  input  logic [31:0]              wb_dat_i,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     wb_rty_o,
  output logic                     wb_stall_o,
  output logic [31:0]              wb_dat_o,
  input  logic [N_CH*SAMPLE_W-1:0] samples_i,
  output logic                     irq_o
);

  logic                rd_busy, wr_busy;
  logic                rd_req, wr_req;
  logic [31:0]         adr_b;
  logic [31:0]         wmask;
  logic                hit_alarm, hit_mask;
  logic [31:0]         rd_word;
  logic [N_CH-1:0]     alarm_q, mask_q, alarm_clr;
  logic [N_CH-1:0]     viol, thr_we;
  logic [SAMPLE_W-1:0] smp_q [N_CH];
  logic [SAMPLE_W-1:0] lo_q  [N_CH];
  logic [SAMPLE_W-1:0] hi_q  [N_CH];
  logic                unused_adr;

  assign unused_adr = ^wb_adr_i[1:0];

  assign rd_req = wb_cyc_i & wb_stb_i & ~wb_we_i & ~rd_busy;
  assign wr_req = wb_cyc_i & wb_stb_i &  wb_we_i & ~wr_busy;

  assign adr_b     = 32'({wb_adr_i[ADR_W-1:2], 2'b00});
  assign wmask     = lane_mask(wb_sel_i);
  assign hit_alarm = (adr_b == OFS_ALARM);
  assign hit_mask  = (adr_b == OFS_MASK);

  assign wb_err_o   = 1'b0;
  assign wb_rty_o   = 1'b0;
  assign wb_stall_o = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign irq_o      = |(alarm_q & mask_q);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign thr_we[c] = wr_req && (adr_b == (OFS_THRESH0 + OFS_STRIDE * 32'(c)));

    wb_thresh_chan #(.SAMPLE_W(SAMPLE_W)) u_chan (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .sample   (samples_i[c*SAMPLE_W +: SAMPLE_W]),
      .wr_en    (thr_we[c]),
      .wdata    (wb_dat_i),
      .wmask    (wmask),
      .sample_q (smp_q[c]),
      .low_q    (lo_q[c]),
      .high_q   (hi_q[c]),
      .viol     (viol[c])
    );
  end

  // Unmapped addresses fall through to zero.
  always_comb begin
    rd_word = '0;
    if (hit_alarm) rd_word[N_CH-1:0] = alarm_q;
    if (hit_mask)  rd_word[N_CH-1:0] = mask_q;
    for (int c = 0; c < N_CH; c++) begin
      if (adr_b == (OFS_THRESH0 + OFS_STRIDE * 32'(c))) begin
        rd_word[LOW_LSB +: SAMPLE_W]  = lo_q[c];
        rd_word[HIGH_LSB +: SAMPLE_W] = hi_q[c];
      end
      if (adr_b == (OFS_SAMPLE0 + OFS_STRIDE * 32'(c))) begin
        rd_word[SAMPLE_W-1:0] = smp_q[c];
      end
    end
  end

  assign alarm_clr = (wr_req && hit_alarm) ? (wb_dat_i[N_CH-1:0] & wmask[N_CH-1:0]) : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_busy  <= 1'b0;
      wr_busy  <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      alarm_q  <= '0;
      mask_q   <= '0;
    end else begin
      wb_ack_o <= rd_req | wr_req;

      if (rd_req)        rd_busy <= 1'b1;
      else if (wb_ack_o) rd_busy <= 1'b0;

      if (wr_req)        wr_busy <= 1'b1;
      else if (wb_ack_o) wr_busy <= 1'b0;

      if (rd_req) wb_dat_o <= rd_word;

      if (wr_req && hit_mask) begin
        mask_q <= (mask_q & ~wmask[N_CH-1:0]) | (wb_dat_i[N_CH-1:0] & wmask[N_CH-1:0]);
      end

      // A violation in the same cycle as the clear keeps the bit set.
      alarm_q <= (alarm_q & ~alarm_clr) | viol;
    end
  end

endmodule

// File: tb/tb_wb_thresh_bank.sv
// Self-checking bench for wb_thresh_bank: bus reads are scored against an expected queue.
module tb_wb_thresh_bank;

  localparam int N_CH     = 8;
  localparam int SAMPLE_W = 16;
  localparam int ADR_W    = 7;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [N_CH*SAMPLE_W-1:0] samples;
  logic                     irq;
  int                       checks = 0;
  int                       errors = 0;
  logic [31:0]              exp_q[$];

  wb_thresh_bank_if #(.ADR_W(ADR_W)) bus ();

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  wb_thresh_bank #(.N_CH(N_CH), .SAMPLE_W(SAMPLE_W), .ADR_W(ADR_W)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .wb_cyc_i   (bus.cyc),
    .wb_stb_i   (bus.stb),
    .wb_adr_i   (bus.adr),
    .wb_sel_i   (bus.sel),
    .wb_we_i    (bus.we),
    .wb_dat_i   (bus.dat_w),
    .wb_ack_o   (bus.ack),
    .wb_err_o   (bus.err),
    .wb_rty_o   (bus.rty),
    .wb_stall_o (bus.stall),
    .wb_dat_o   (bus.dat_r),
    .samples_i  (samples),
    .irq_o      (irq)
  );

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = '0; bus.sel = 4'h0; bus.dat_w = '0;
  endtask

  task automatic set_sample(input int ch, input logic [SAMPLE_W-1:0] v);
    samples[ch*SAMPLE_W +: SAMPLE_W] = v;
  endtask

  task automatic bus_xfer(input logic is_wr, input logic [ADR_W-1:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output int lat);
    logic got;
    got = 1'b0; rd = 'x; lat = 0;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = is_wr;
    bus.adr = a; bus.dat_w = d; bus.sel = s;
    while (!got && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.ack === 1'b1) begin
        got = 1'b1;
        rd  = bus.dat_r;
      end
    end
    idle();
    if (!got) begin
      checks++; errors++;
      $display("FAIL bus_timeout: addr %02h got no ack within %0d cycles", a, lat);
    end
    tick(1);
  endtask

  task automatic bus_read(input logic [ADR_W-1:0] a, output logic [31:0] rd, output int lat);
    bus_xfer(1'b0, a, 32'h0, 4'hF, rd, lat);
  endtask

  task automatic bus_write(input logic [ADR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int lat);
    logic [31:0] dummy;
    bus_xfer(1'b1, a, d, s, dummy, lat);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] rd, exp;
    int lat;
    idle();
    samples = '0;
    rst_n = 1'b0;
    tick(3);
    checks++;
    if (bus.ack !== 1'b0 || irq !== 1'b0 || bus.dat_r !== 32'h0) begin
      errors++;
      $display("FAIL rst_outputs: ack=%b irq=%b dat=%08h, need 0 0 00000000", bus.ack, irq, bus.dat_r);
    end
    rst_n = 1'b1;

    exp_q.push_back(32'hFFFF_0000);
    bus_read(7'h08, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL rst_thresh0: got %08h need %08h", rd, exp); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL rst_ack_latency: got %0d need 1", lat); end
    checks++;
    if (bus.ack !== 1'b0) begin errors++; $display("FAIL ack_width: ack still %b", bus.ack); end

    exp_q.push_back(32'h0);
    bus_read(7'h00, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL rst_alarm: got %08h need %08h", rd, exp); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL rst_alarm_latency: got %0d need 1", lat); end

    exp_q.push_back(32'h0);
    bus_read(7'h04, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL rst_mask: got %08h need %08h", rd, exp); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b need 0", irq); end
  endtask

  task automatic test_violation();
    logic [31:0] rd, exp;
    int lat;
    set_sample(2, 16'h0150);
    set_sample(3, 16'h0100);
    tick(2);
    bus_write(7'h18, 32'h0200_0100, 4'hF, lat);
    bus_write(7'h04, 32'h0000_0004, 4'hF, lat);

    exp_q.push_back(32'h0);
    bus_read(7'h00, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL in_window_alarm: got %08h need %08h", rd, exp); end

    set_sample(2, 16'h0300);
    tick(1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL alarm_early: irq=%b need 0 one edge after sample", irq); end
    tick(1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL alarm_set_irq: irq=%b need 1", irq); end

    exp_q.push_back(32'h0000_0004);
    bus_read(7'h00, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL alarm_set: got %08h need %08h", rd, exp); end

    bus_write(7'h00, 32'h0000_0004, 4'hF, lat);
    exp_q.push_back(32'h0000_0004);
    bus_read(7'h00, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL set_wins: got %08h need %08h", rd, exp); end

    set_sample(2, 16'h0150);
    tick(2);
    bus_write(7'h00, 32'h0000_0004, 4'hF, lat);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: irq=%b need 0", irq); end
    exp_q.push_back(32'h0);
    bus_read(7'h00, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL w1c_clear: got %08h need %08h", rd, exp); end

    // Samples exactly on LOW and HIGH are inside the window; one above HIGH is not.
    bus_write(7'h20, 32'h0200_0100, 4'hF, lat);
    set_sample(3, 16'h0200);
    tick(2);
    exp_q.push_back(32'h0);
    bus_read(7'h00, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL edge_inclusive: got %08h need %08h", rd, exp); end
    set_sample(3, 16'h0201);
    tick(2);
    exp_q.push_back(32'h0000_0008);
    bus_read(7'h00, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL above_high: got %08h need %08h", rd, exp); end
    set_sample(3, 16'h0150);
    tick(2);
    bus_write(7'h00, 32'h0000_0008, 4'hF, lat);

    // Inverted window: alarm re-sets immediately after a clear.
    bus_write(7'h10, 32'h0001_0005, 4'hF, lat);
    tick(2);
    bus_write(7'h00, 32'h0000_0002, 4'hF, lat);
    exp_q.push_back(32'h0000_0002);
    bus_read(7'h00, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL inverted_window: got %08h need %08h", rd, exp); end
    bus_write(7'h10, 32'hFFFF_0000, 4'hF, lat);
    bus_write(7'h00, 32'h0000_0002, 4'hF, lat);
    exp_q.push_back(32'h0);
    bus_read(7'h00, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL restore_clear: got %08h need %08h", rd, exp); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd, exp;
    int lat;
    set_sample(0, 16'h6000);
    tick(2);
    bus_write(7'h08, 32'hAAAA_5555, 4'b0011, lat);
    exp_q.push_back(32'hFFFF_5555);
    bus_read(7'h08, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL thresh_lanes: got %08h need %08h", rd, exp); end

    bus_write(7'h04, 32'h0000_00FF, 4'b0010, lat);
    exp_q.push_back(32'h0000_0004);
    bus_read(7'h04, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL mask_lanes: got %08h need %08h", rd, exp); end

    exp_q.push_back(32'h0);
    bus_read(7'h00, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL lanes_alarm: got %08h need %08h", rd, exp); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd, exp;
    int lat;
    bus_write(7'h7C, 32'hFFFF_FFFF, 4'hF, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL unmapped_wr_ack: latency %0d need 1", lat); end
    exp_q.push_back(32'h0);
    bus_read(7'h7C, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp || lat !== 1) begin
      errors++; $display("FAIL unmapped_rd: got %08h lat %0d need %08h lat 1", rd, lat, exp);
    end
    exp_q.push_back(32'h0000_0004);
    bus_read(7'h04, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL unmapped_mask: got %08h need %08h", rd, exp); end
    exp_q.push_back(32'h0200_0100);
    bus_read(7'h18, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL unmapped_thresh2: got %08h need %08h", rd, exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    int acks, cyc_cnt, extra;
    for (int i = 0; i < 3; i++) begin
      logic [SAMPLE_W-1:0] v;
      v = SAMPLE_W'($urandom_range(0, 16'hFFFF));
      set_sample(i, v);
      exp_q.push_back(32'(v));
    end
    tick(2);
    acks = 0; cyc_cnt = 0;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.sel = 4'hF; bus.adr = 7'h0C;
    while (acks < 3 && cyc_cnt < 20) begin
      @(posedge clk);
      #1;
      cyc_cnt++;
      if (bus.ack === 1'b1) begin
        exp = exp_q.pop_front(); checks++;
        if (bus.dat_r !== exp) begin
          errors++; $display("FAIL b2b_data%0d: got %08h need %08h", acks, bus.dat_r, exp);
        end
        acks++;
        if (acks < 3) bus.adr = 7'(12 + 8 * acks);
        else idle();
      end else begin
        checks++;
        if (bus.stall !== 1'b1) begin errors++; $display("FAIL b2b_stall: stall=%b need 1", bus.stall); end
      end
    end
    extra = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.ack === 1'b1) extra++;
    end
    checks++;
    if (acks !== 3 || extra !== 0) begin
      errors++; $display("FAIL b2b_ack_count: got %0d acks + %0d extra, need 3 + 0", acks, extra);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, exp;
    int lat, acks;
    bus_write(7'h04, 32'h0000_00FF, 4'hF, lat);
    set_sample(0, 16'h1234);
    tick(2);
    exp_q.push_back(32'h0000_1234);
    bus_read(7'h0C, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL pre_rst_sample: got %08h need %08h", rd, exp); end

    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.sel = 4'hF; bus.adr = 7'h08;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ack !== 1'b0 || bus.dat_r !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL async_rst: ack=%b dat=%08h irq=%b need 0 00000000 0", bus.ack, bus.dat_r, irq);
    end
    samples = '0;
    @(posedge clk);
    #1;
    idle();
    tick(1);
    rst_n = 1'b1;
    acks = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.ack === 1'b1) acks++;
    end
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL aborted_ack: got %0d acks need 0", acks); end

    exp_q.push_back(32'h0);
    bus_read(7'h00, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL post_rst_alarm: got %08h need %08h", rd, exp); end
    exp_q.push_back(32'h0);
    bus_read(7'h04, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL post_rst_mask: got %08h need %08h", rd, exp); end
    for (int c = 0; c < N_CH; c++) begin
      exp_q.push_back(32'hFFFF_0000);
      bus_read(7'(8 + 8 * c), rd, lat);
      exp = exp_q.pop_front(); checks++;
      if (rd !== exp) begin errors++; $display("FAIL post_rst_thresh%0d: got %08h need %08h", c, rd, exp); end
    end
    exp_q.push_back(32'h0);
    bus_read(7'h0C, rd, lat);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("FAIL post_rst_sample0: got %08h need %08h", rd, exp); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL post_rst_irq: got %b need 0", irq); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_violation();
    test_byte_lanes();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
